// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for one xfft core: config handshake, ADC sample streaming with tlast
// framing, and spectrum write-back into an external result RAM.
module fft_frame_ctrl #(
   parameter int unsigned FFT_LEN = 1024,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned AD_W    = 10
) (
   input  logic              sys_clk_i,
   input  logic              sys_rst_ni,
   input  logic              start_i,
   input  logic              dir_i,
   input  logic              continuous_i,
   input  logic [AD_W-1:0]   ad_data_i,
   input  logic              ad_valid_i,
   output logic [7:0]        cfg_tdata_o,
   output logic              cfg_tvalid_o,
   input  logic              cfg_tready_i,
   output logic [31:0]       s_tdata_o,
   output logic              s_tvalid_o,
   input  logic              s_tready_i,
   output logic              s_tlast_o,
   input  logic              m_tvalid_i,
   input  logic              m_tlast_i,
   input  logic [31:0]       m_tdata_i,
   output logic              m_tready_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [31:0]       ram_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        err_o
);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StConfig = 3'd1;
   localparam logic [2:0] StLoad   = 3'd2;
   localparam logic [2:0] StDrain  = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(FFT_LEN - 1);

   logic [2:0]        state_q, state_d;
   logic              dir_q, dir_d;
   logic              cfg_tvalid_q, cfg_tvalid_d;
   logic [31:0]       s_tdata_q, s_tdata_d;
   logic              s_tvalid_q, s_tvalid_d;
   logic              s_tlast_q, s_tlast_d;
   logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
   logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
   logic              m_tready_q;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [31:0]       ram_wdata_q, ram_wdata_d;
   logic              done_q, done_d;
   logic [1:0]        err_q, err_d;

   logic              in_hs;
   logic              out_beat;
   logic [ADDR_W-1:0] next_idx;
   logic [15:0]       smp_real;

   // Offset-binary to two's complement is an MSB flip, then sign-extend.
   assign smp_real = {{(16-AD_W){~ad_data_i[AD_W-1]}}, ~ad_data_i[AD_W-1], ad_data_i[AD_W-2:0]};
   assign in_hs    = s_tvalid_q & s_tready_i;
   assign out_beat = m_tvalid_i & m_tready_q;
   assign next_idx = in_cnt_q + ADDR_W'(in_hs);

   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      cfg_tvalid_d = cfg_tvalid_q;
      s_tdata_d    = s_tdata_q;
      s_tvalid_d   = s_tvalid_q;
      s_tlast_d    = s_tlast_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      ram_we_d     = out_beat;
      ram_addr_d   = ram_addr_q;
      ram_wdata_d  = ram_wdata_q;
      done_d       = 1'b0;
      err_d        = err_q;

      // Output beats are written back in every state.
      if (out_beat) begin
         ram_addr_d  = out_cnt_q;
         ram_wdata_d = m_tdata_i;
         out_cnt_d   = out_cnt_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (start_i) begin
               dir_d        = dir_i;
               err_d        = 2'b00;
               cfg_tvalid_d = 1'b1;
               state_d      = StConfig;
            end
         end
         StConfig: begin
            if (cfg_tvalid_q && cfg_tready_i) begin
               cfg_tvalid_d = 1'b0;
               in_cnt_d     = '0;
               state_d      = StLoad;
            end
         end
         StLoad: begin
            if (in_hs) in_cnt_d = in_cnt_q + 1'b1;
            if (in_hs && s_tlast_q) begin
               s_tvalid_d = 1'b0;
               s_tlast_d  = 1'b0;
               state_d    = StDrain;
            end else if (!s_tvalid_q || s_tready_i) begin
               s_tvalid_d = ad_valid_i;
               s_tlast_d  = ad_valid_i && (next_idx == LastIdx);
               if (ad_valid_i) s_tdata_d = {16'h0000, smp_real};
            end else if (ad_valid_i) begin
               err_d[0] = 1'b1;
            end
         end
         StDrain: begin
            if (out_beat && m_tlast_i) begin
               if (out_cnt_q != LastIdx) err_d[1] = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            // Two cycles: the first raises done, the second leaves.
            out_cnt_d = '0;
            if (!done_q) begin
               done_d = 1'b1;
            end else begin
               cfg_tvalid_d = continuous_i;
               state_d      = continuous_i ? StConfig : StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         state_q      <= StIdle;
         dir_q        <= 1'b1;
         cfg_tvalid_q <= 1'b0;
         s_tdata_q    <= '0;
         s_tvalid_q   <= 1'b0;
         s_tlast_q    <= 1'b0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         m_tready_q   <= 1'b0;
         ram_we_q     <= 1'b0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         done_q       <= 1'b0;
         err_q        <= 2'b00;
      end else begin
         state_q      <= state_d;
         dir_q        <= dir_d;
         cfg_tvalid_q <= cfg_tvalid_d;
         s_tdata_q    <= s_tdata_d;
         s_tvalid_q   <= s_tvalid_d;
         s_tlast_q    <= s_tlast_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         m_tready_q   <= 1'b1;
         ram_we_q     <= ram_we_d;
         ram_addr_q   <= ram_addr_d;
         ram_wdata_q  <= ram_wdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // dir is only presented while config is offered so reset leaves every output low.
   assign cfg_tdata_o  = cfg_tvalid_q ? {7'b0, dir_q} : 8'h00;
   assign cfg_tvalid_o = cfg_tvalid_q;
   assign s_tdata_o    = s_tdata_q;
   assign s_tvalid_o   = s_tvalid_q;
   assign s_tlast_o    = s_tlast_q;
   assign m_tready_o   = m_tready_q;
   assign ram_we_o     = ram_we_q;
   assign ram_addr_o   = ram_addr_q;
   assign ram_wdata_o  = ram_wdata_q;
   assign busy_o       = (state_q != StIdle);
   assign done_o       = done_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Bench for fft_frame_ctrl: a frame-level model checked every cycle on the falling edge,
// plus directed frames with hand-computed expectations.
module tb_fft_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0, dir = 1'b0, continuous = 1'b0;
   logic [9:0]  ad_data = '0;
   logic        ad_valid = 1'b0;
   logic [7:0]  cfg_tdata;
   logic        cfg_tvalid;
   logic        cfg_tready = 1'b0;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tlast;
   logic        s_tready = 1'b1;
   logic        m_tvalid = 1'b0, m_tlast = 1'b0;
   logic [31:0] m_tdata = '0;
   logic        m_tready, ram_we, busy, done;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [1:0]  err;

   fft_frame_ctrl #(.FFT_LEN(1024), .ADDR_W(10), .AD_W(10)) dut (
      .sys_clk_i(clk), .sys_rst_ni(rst_n), .start_i(start), .dir_i(dir),
      .continuous_i(continuous), .ad_data_i(ad_data), .ad_valid_i(ad_valid),
      .cfg_tdata_o(cfg_tdata), .cfg_tvalid_o(cfg_tvalid), .cfg_tready_i(cfg_tready),
      .s_tdata_o(s_tdata), .s_tvalid_o(s_tvalid), .s_tready_i(s_tready), .s_tlast_o(s_tlast),
      .m_tvalid_i(m_tvalid), .m_tlast_i(m_tlast), .m_tdata_i(m_tdata), .m_tready_o(m_tready),
      .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
      .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [15:0] conv(input logic [9:0] a);
      int v;
      v = int'(a) - 512;
      return v[15:0];
   endfunction

   // Frame-level model state
   bit          m_active, m_cfg_pend, m_loading, m_draining, m_dir;
   logic [1:0]  m_err;
   int          m_hs_cnt, m_acc_cnt, m_out_idx;
   logic [9:0]  pend_q[$];
   logic [9:0]  cmp_a;
   bit          prev_beat, prev_stall, prev_slast, end_set, was_active;
   logic [9:0]  prev_idx;
   logic [31:0] prev_data, prev_sdata;
   bit [1:0]    end_hist;
   int          f_beats, last_ram_addr;
   logic [31:0] f_first, f_last;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_active = 0; m_cfg_pend = 0; m_loading = 0; m_draining = 0; m_dir = 1;
         m_err = 2'b00; m_hs_cnt = 0; m_acc_cnt = 0; m_out_idx = 0;
         pend_q.delete(); prev_beat = 0; prev_stall = 0; end_hist = 2'b00;
      end else begin
         chk("busy", 32'(busy), 32'(m_active));
         chk("cfg_tvalid", 32'(cfg_tvalid), 32'(m_cfg_pend));
         chk("cfg_tdata", 32'(cfg_tdata), m_cfg_pend ? 32'(m_dir) : 32'h0);
         chk("s_tvalid", 32'(s_tvalid), 32'(pend_q.size() != 0));
         chk("m_tready", 32'(m_tready), 32'h1);
         chk("ram_we", 32'(ram_we), 32'(prev_beat));
         if (prev_beat) begin
            chk("ram_addr", 32'(ram_addr), 32'(prev_idx));
            chk("ram_wdata", ram_wdata, prev_data);
            last_ram_addr = int'(ram_addr);
         end
         if (prev_stall) begin
            chk("stall_tdata", s_tdata, prev_sdata);
            chk("stall_tlast", 32'(s_tlast), 32'(prev_slast));
         end
         chk("done", 32'(done), 32'(end_hist[1]));
         chk("err", 32'(err), 32'(m_err));

         was_active = m_active;
         prev_stall = s_tvalid && !s_tready;
         prev_sdata = s_tdata;
         prev_slast = s_tlast;
         if (s_tvalid && s_tready && pend_q.size() != 0) begin
            cmp_a = pend_q.pop_front();
            chk("s_tdata", s_tdata, {16'h0000, conv(cmp_a)});
            chk("s_tlast", 32'(s_tlast), 32'(m_hs_cnt == 1023));
            if (m_hs_cnt == 0) f_first = s_tdata;
            m_hs_cnt++;
            f_beats = m_hs_cnt;
            if (m_hs_cnt == 1024) begin
               m_loading = 0; m_draining = 1; f_last = s_tdata;
            end
         end
         if (m_loading && ad_valid) begin
            if (prev_stall) m_err[0] = 1'b1;
            else if (m_acc_cnt < 1024) begin
               pend_q.push_back(ad_data);
               m_acc_cnt++;
            end
         end
         if (m_cfg_pend && cfg_tready) begin
            m_cfg_pend = 0; m_loading = 1; m_hs_cnt = 0; m_acc_cnt = 0; f_beats = 0;
         end
         end_set   = 0;
         prev_beat = m_tvalid;
         prev_idx  = 10'(m_out_idx);
         prev_data = m_tdata;
         if (m_tvalid) begin
            if (m_draining && m_tlast) begin
               if (m_out_idx != 1023) m_err[1] = 1'b1;
               m_draining = 0;
               end_set = 1;
            end
            m_out_idx = (m_out_idx + 1) % 1024;
         end
         if (end_hist[1]) begin
            m_out_idx = 0;
            if (continuous) m_cfg_pend = 1;
            else m_active = 0;
         end
         end_hist = {end_hist[0], end_set};
         if (start && !was_active) begin
            m_active = 1; m_dir = dir; m_err = 2'b00; m_cfg_pend = 1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic d, input logic c);
      start = 1'b1; dir = d; continuous = c;
      tick();
      start = 1'b0;
   endtask

   task automatic do_cfg();
      cfg_tready = 1'b1;
      tick();
      cfg_tready = 1'b0;
   endtask

   task automatic run_load(input int stall_at, input int stall_len, input int abort_at);
      int smp;
      smp = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (!m_loading) break;
         if (abort_at > 0 && m_hs_cnt >= abort_at) break;
         ad_valid = 1'b1;
         ad_data  = 10'(smp);
         smp++;
         s_tready = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
         tick();
      end
      if (abort_at == 0) begin
         ad_valid = 1'b0;
         s_tready = 1'b1;
         chk("load_finished", 32'(m_loading), 32'h0);
      end
   endtask

   task automatic run_drain(input int n, input int tlast_at);
      for (int i = 0; i < n; i++) begin
         m_tvalid = 1'b1;
         m_tdata  = 32'(i) * 32'd65539;
         m_tlast  = (i == tlast_at);
         tick();
      end
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int lat;
      lat = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) break;
         lat++;
      end
      chk(name, 32'(lat), 32'd2);
   endtask

   task automatic reset_check(input string name);
      chk({name, "_busy"}, 32'(busy), 32'h0);
      chk({name, "_cfg"}, {23'h0, cfg_tvalid, cfg_tdata}, 32'h0);
      chk({name, "_s"}, {29'h0, s_tvalid, s_tlast, m_tready}, 32'h0);
      chk({name, "_sdata"}, s_tdata, 32'h0);
      chk({name, "_ram"}, {21'h0, ram_we, ram_addr}, 32'h0);
      chk({name, "_done_err"}, {29'h0, done, err}, 32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset_check("reset");
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();

      // Frame 1: forward FFT, config stalled 5 cycles, clean ramp, full drain
      do_start(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("cfg_hold_valid", 32'(cfg_tvalid), 32'h1);
         chk("cfg_hold_data", 32'(cfg_tdata), 32'h01);
         tick();
      end
      do_cfg();
      run_load(0, 0, 0);
      chk("f1_beats", 32'(f_beats), 32'd1024);
      chk("f1_first", f_first, 32'h0000FE00);
      chk("f1_last", f_last, 32'h000001FF);
      chk("f1_err_load", 32'(err), 32'h0);
      run_drain(1024, 1023);
      wait_done("f1_done_lat");
      chk("f1_last_addr", 32'(last_ram_addr), 32'd1023);
      chk("f1_err", 32'(err), 32'h0);
      @(negedge clk);
      chk("f1_idle", 32'(busy), 32'h0);
      tick();

      // Frame 2: IFFT, 3-cycle input stall, early m_tlast
      do_start(1'b0, 1'b0);
      do_cfg();
      run_load(100, 3, 0);
      chk("f2_beats", 32'(f_beats), 32'd1024);
      chk("f2_last", f_last, 32'h0000FE02);
      chk("f2_err_overrun", 32'(err), 32'h1);
      run_drain(512, 511);
      wait_done("f2_done_lat");
      chk("f2_last_addr", 32'(last_ram_addr), 32'd511);
      chk("f2_err", 32'(err), 32'h3);
      tick();

      // Frame 3: continuous IFFT; restart without start pulse
      do_start(1'b0, 1'b1);
      do_cfg();
      run_load(0, 0, 0);
      run_drain(1024, 1023);
      wait_done("f3_done_lat");
      @(negedge clk);
      chk("f3_auto_cfg_valid", 32'(cfg_tvalid), 32'h1);
      chk("f3_auto_cfg_data", 32'(cfg_tdata), 32'h00);
      chk("f3_err", 32'(err), 32'h0);

      // Frame 4: auto-restarted, reset asynchronously after 300 beats
      @(posedge clk);
      #1;
      continuous = 1'b0;
      do_cfg();
      run_load(0, 0, 300);
      chk("f4_abort_beats", 32'(f_beats), 32'd300);
      rst_n = 1'b0;
      #1;
      ad_valid = 1'b0;
      s_tready = 1'b1;
      reset_check("midload_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("post_reset_idle", 32'(busy), 32'h0);
      tick();

      // Frame 5: full frame after the mid-frame reset
      do_start(1'b1, 1'b0);
      do_cfg();
      run_load(0, 0, 0);
      chk("f5_beats", 32'(f_beats), 32'd1024);
      chk("f5_first", f_first, 32'h0000FE00);
      chk("f5_last", f_last, 32'h000001FF);
      run_drain(1024, 1023);
      wait_done("f5_done_lat");
      chk("f5_err", 32'(err), 32'h0);
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
